// File: rtl/pc_stack_sequencer_pkg.sv
// Shared definitions for the PC sequencer: op encodings and a width helper.
package pc_stack_sequencer_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_INC    = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    // Number of bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_stack_sequencer_ras_stack.sv
// Return-address stack: DEPTH x PC_W entries, push/pop, occupancy count.
// Only the stack pointer is reset; entry contents are don't-care after reset.
module pc_stack_sequencer_ras_stack
    import pc_stack_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 8,
    parameter int SP_W  = clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] top_o,
    output logic [SP_W-1:0] sp_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_d;
    logic [SP_W-1:0] top_idx;
    logic [PC_W-1:0] mem_q [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign sp_o    = sp_q;

    // Overflow/underflow requests are dropped here; push has priority if both arrive.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !push_i && !empty_o;

    assign top_idx = empty_o ? '0 : (sp_q - 1'b1);

    // Next stack pointer from the qualified push/pop.
    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + 1'b1;
        end else if (do_pop) begin
            sp_d = sp_q - 1'b1;
        end
    end

    // Stack pointer register with async reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage: write the slot just above the current top on push.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (sp_q == SP_W'(i))) begin
                mem_q[i] <= push_data_i;
            end
        end
    end

    // Top-of-stack read mux; compare form keeps non power-of-two depths clean.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == SP_W'(i)) begin
                top_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/pc_stack_sequencer.sv
// Program counter with return-address stack. The next PC is computed from the
// op sampled at a clock edge; pc_out_o is purely registered.
module pc_stack_sequencer
    import pc_stack_sequencer_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int STEP      = 4,
    parameter int OFF_W     = 6,
    parameter int DEPTH     = 4,
    parameter int RESET_VEC = 0,
    localparam int SP_W     = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [2:0]       op_i,
    input  logic [PC_W-1:0]  target_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic             cond_i,
    input  logic             clr_err_i,
    output logic [PC_W-1:0]  pc_out_o,
    output logic [SP_W-1:0]  sp_o,
    output logic             stack_full_o,
    output logic             stack_empty_o,
    output logic             ovf_err_o,
    output logic             unf_err_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            unf_q;
    logic            unf_d;

    logic [PC_W-1:0] pc_step;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_branch;
    logic [PC_W-1:0] ret_addr;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic            unf_set;
    logic            full;
    logic            empty;

    pc_stack_sequencer_ras_stack #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .SP_W  (SP_W)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_step),
        .top_o       (ret_addr),
        .sp_o        (sp_o),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Sign-extend the branch offset to PC width (offset assumed no wider than PC).
    always_comb begin
        off_ext                = {PC_W{offset_i[OFF_W-1]}};
        off_ext[OFF_W-1:0]     = offset_i;
    end

    // Both sums wrap modulo 2^PC_W by truncation.
    assign pc_step   = pc_q + PC_W'(STEP);
    assign pc_branch = pc_q + off_ext;

    // Op decode: next PC, stack requests and new error events.
    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en_i) begin
            case (op_i)
                OP_INC: begin
                    pc_d = pc_step;
                end
                OP_JUMP: begin
                    pc_d = target_i;
                end
                OP_BRANCH: begin
                    pc_d = cond_i ? pc_branch : pc_step;
                end
                OP_CALL: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = target_i;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = ret_addr;
                    end
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    // Sticky errors: a new event beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_set ? 1'b1 : (clr_err_i ? 1'b0 : ovf_q);
        unf_d = unf_set ? 1'b1 : (clr_err_i ? 1'b0 : unf_q);
    end

    // PC and error flag registers with async reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q  <= PC_W'(RESET_VEC);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc_out_o      = pc_q;
    assign stack_full_o  = full;
    assign stack_empty_o = empty;
    assign ovf_err_o     = ovf_q;
    assign unf_err_o     = unf_q;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Bench for pc_stack_sequencer: directed plan followed by random ops, all
// checked against a queue-based reference model.
module tb_pc_stack_sequencer;

    localparam int PC_W      = 8;
    localparam int STEP      = 4;
    localparam int OFF_W     = 6;
    localparam int DEPTH     = 4;
    localparam int RESET_VEC = 0;
    localparam int SP_W      = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       op;
    logic [PC_W-1:0]  target;
    logic [OFF_W-1:0] offset;
    logic             cond;
    logic             clr_err;
    logic [PC_W-1:0]  pc_out;
    logic [SP_W-1:0]  sp;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf_err;
    logic             unf_err;

    int checks = 0;
    int errors = 0;

    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    pc_stack_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .op_i          (op),
        .target_i      (target),
        .offset_i      (offset),
        .cond_i        (cond),
        .clr_err_i     (clr_err),
        .pc_out_o      (pc_out),
        .sp_o          (sp),
        .stack_full_o  (stack_full),
        .stack_empty_o (stack_empty),
        .ovf_err_o     (ovf_err),
        .unf_err_o     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_VEC;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_all(input string where);
        chk({where, "/pc"},    32'(pc_out),      32'(m_pc));
        chk({where, "/sp"},    32'(sp),          32'(m_stack.size()));
        chk({where, "/full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        chk({where, "/empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        chk({where, "/ovf"},   32'(ovf_err),     32'(m_ovf));
        chk({where, "/unf"},   32'(unf_err),     32'(m_unf));
    endtask

    // Drive one op, let one edge pass, update the model, then compare.
    task automatic step(input bit e, input int o, input int tgt, input int off,
                        input bit c, input bit clr, input string where);
        int so;
        bit new_o;
        bit new_u;
        en      = e;
        op      = 3'(o);
        target  = PC_W'(tgt);
        offset  = OFF_W'(off);
        cond    = c;
        clr_err = clr;
        @(posedge clk);
        #1;
        new_o = 1'b0;
        new_u = 1'b0;
        if (e) begin
            case (o)
                1: m_pc = (m_pc + STEP) % 256;
                2: m_pc = tgt & 255;
                3: begin
                    if (c) begin
                        so = off & 63;
                        if (so >= 32) so = so - 64;
                        m_pc = (m_pc + so) & 255;
                    end else begin
                        m_pc = (m_pc + STEP) % 256;
                    end
                end
                4: begin
                    if (m_stack.size() == DEPTH) begin
                        new_o = 1'b1;
                    end else begin
                        m_stack.push_back((m_pc + STEP) % 256);
                        m_pc = tgt & 255;
                    end
                end
                5: begin
                    if (m_stack.size() == 0) begin
                        new_u = 1'b1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                default: ;
            endcase
        end
        m_ovf = new_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = new_u ? 1'b1 : (clr ? 1'b0 : m_unf);
        check_all(where);
    endtask

    task automatic mid_reset(input string where);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(where);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        op      = '0;
        target  = '0;
        offset  = '0;
        cond    = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Increment sequence, then async reset between edges.
        step(1, 1, 0, 0, 0, 0, "inc1");
        step(1, 1, 0, 0, 0, 0, "inc2");
        step(1, 1, 0, 0, 0, 0, "inc3");
        chk("inc3_const", 32'(pc_out), 32'h0C);
        mid_reset("rst_mid");
        chk("rst_mid_const", 32'(pc_out), 32'h00);

        // Wrap and branches.
        step(1, 2, 'hFC, 0, 0, 0, "jmp_fc");
        step(1, 1, 0, 0, 0, 0, "inc_wrap");
        chk("inc_wrap_const", 32'(pc_out), 32'h00);
        step(1, 2, 'h04, 0, 0, 0, "jmp_04a");
        step(1, 3, 0, 'b111000, 1, 0, "br_taken");
        chk("br_taken_const", 32'(pc_out), 32'hFC);
        step(1, 2, 'h04, 0, 0, 0, "jmp_04b");
        step(1, 3, 0, 'b111000, 0, 0, "br_fall");
        chk("br_fall_const", 32'(pc_out), 32'h08);

        // Enable low holds everything.
        step(1, 2, 'h40, 0, 0, 0, "jmp_40");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, "en_low");
        chk("en_low_const", 32'(pc_out), 32'h40);

        // Nested call/return.
        step(1, 2, 'h10, 0, 0, 0, "jmp_10");
        step(1, 4, 'h80, 0, 0, 0, "call80");
        step(1, 4, 'h90, 0, 0, 0, "call90");
        chk("call_sp_const", 32'(sp), 32'd2);
        step(1, 5, 0, 0, 0, 0, "ret1");
        chk("ret1_const", 32'(pc_out), 32'h84);
        step(1, 5, 0, 0, 0, 0, "ret2");
        chk("ret2_const", 32'(pc_out), 32'h14);

        // Overflow and underflow.
        for (int i = 0; i < DEPTH; i++) step(1, 4, 'h20 + 16 * i, 0, 0, 0, "fill");
        chk("full_const", 32'(stack_full), 32'd1);
        step(1, 4, 'hA0, 0, 0, 0, "call_full");
        chk("ovf_const", 32'(ovf_err), 32'd1);
        chk("ovf_pc_const", 32'(pc_out), 32'h50);
        for (int i = 0; i < DEPTH; i++) step(1, 5, 0, 0, 0, 0, "drain");
        step(1, 5, 0, 0, 0, 0, "ret_empty");
        chk("unf_const", 32'(unf_err), 32'd1);

        // Clear racing a new overflow, then a plain clear.
        for (int i = 0; i < DEPTH; i++) step(1, 4, 'h60 + 4 * i, 0, 0, 0, "refill");
        step(1, 4, 'hA0, 0, 0, 1, "clr_vs_ovf");
        chk("clr_vs_ovf_o", 32'(ovf_err), 32'd1);
        chk("clr_vs_ovf_u", 32'(unf_err), 32'd0);
        step(1, 0, 0, 0, 0, 1, "clr_only");
        chk("clr_only_o", 32'(ovf_err), 32'd0);

        // Random traffic, with an occasional async reset.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) != 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, "rand");
            if ((n % 131) == 130) mid_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_sequencer.md
Name: pc_stack_sequencer

Overview:
Parametrised program counter with a hardware return-address stack, successor to the fixed 8-bit PC.
- Supports hold, increment by a configurable step, absolute jump, conditional relative branch, call and return.
- Sits between instruction decode and instruction fetch; pc_out drives the fetch address.
- All state is registered; the next PC is computed from the op sampled on the previous clock edge.

Parameters:
- PC_W, 8, PC and stack-entry width in bits.
- STEP, 4, increment added by INC and used for CALL return address (pc+STEP).
- OFF_W, 6, width of signed branch offset (two's complement).
- DEPTH, 4, return-address stack entries (>=1).
- RESET_VEC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- en  in  1  advance enable; low = every register holds, op ignored.
- op  in  3  0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6-7 reserved (treated as HOLD).
- target  in  PC_W  absolute destination for JUMP/CALL.
- offset  in  OFF_W  signed relative offset for BRANCH.
- cond  in  1  BRANCH taken when high.
- clr_err  in  1  clears sticky error flags.
- pc_out  out  PC_W  current PC (registered).
- sp  out  clog2(DEPTH+1)  number of valid stack entries.
- stack_full  out  1  sp == DEPTH.
- stack_empty  out  1  sp == 0.
- ovf_err  out  1  sticky: CALL attempted while full.
- unf_err  out  1  sticky: RET attempted while empty.

Behaviour:
- Reset (async assert, any time, mid-operation): pc_out=RESET_VEC, sp=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0. Stack contents are don't-care. The first update happens on the first rising edge after deassertion.
- Latency: op/target/offset/cond sampled at rising edge N; pc_out, sp and flags reflect the result after edge N (one-cycle latency, no combinational path from inputs to pc_out).
- en=0: pc, sp and stack hold. clr_err is still honoured.
- HOLD/reserved: pc unchanged.
- INC: pc <= pc + STEP mod 2^PC_W (wraps silently, e.g. 0xFC+4 -> 0x00 at PC_W=8).
- JUMP: pc <= target.
- BRANCH: cond=1 -> pc <= pc + sign_extend(offset) mod 2^PC_W; cond=0 -> pc <= pc + STEP (fall-through).
- CALL, not full: stack[sp] <= pc + STEP (wrapped), sp <= sp+1, pc <= target.
- CALL, full: no push, sp unchanged, pc unchanged, ovf_err <= 1.
- RET, not empty: pc <= stack[sp-1], sp <= sp-1.
- RET, empty: pc unchanged, unf_err <= 1.
- Errors are sticky until clr_err or reset. clr_err in the same cycle as a new error: the error wins (flag stays 1).
- stack_full/stack_empty are decoded from registered sp and are valid at all times.
- DEPTH=1: a single entry; full and empty are mutually exclusive.

Decomposition:
- Shared package: op encoding constants (OP_HOLD..OP_RET), plus a clog2 helper function if the package does not already provide one.
- One natural sub-module: ras_stack (DEPTH x PC_W register array with push/pop, sp, full/empty, async reset of sp only). The PC datapath and op decode stay in the top module.

Test Plan:
- Reset then INC x3 (defaults) -> pc_out 0x00, 0x04, 0x08, 0x0C; assert rst mid-sequence -> pc_out 0x00 immediately, sp=0.
- pc=0xFC, INC -> 0x00. BRANCH offset=6'b111000 (-8), cond=1 from pc=0x04 -> 0xFC; same with cond=0 -> 0x08.
- JUMP target=0x40 -> 0x40; then en=0 with op=INC for 3 cycles -> pc_out stays 0x40.
- From pc=0x10: CALL 0x80, CALL 0x90 -> sp=2, pc=0x90. Then RET -> 0x84, then RET -> 0x14, sp=0, stack_empty=1.
- DEPTH=4: 4 CALLs -> stack_full=1. 5th CALL target=0xA0 -> pc unchanged, ovf_err=1, sp=4. RET on empty stack -> unf_err=1, pc unchanged.
- Errors set, clr_err=1 together with a CALL while full -> ovf_err stays 1, unf_err cleared. Next cycle clr_err alone -> both 0.
